// File: rtl/star_hub_switch_alloc.sv
// Switch allocator for the star hub router: header decode, per-output round-robin, wormhole locks.
// Defining STAR_ALLOC_TIMEOUT_EN adds per-output stall timeouts and the alloc_timeout port.
module star_hub_switch_alloc #(
  parameter int NPORTS      = 10,
  parameter int DEST_W      = 6,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          in_valid,
  input  logic [NPORTS*DEST_W-1:0]   in_dest,
  input  logic [NPORTS-1:0]          in_tail,
  input  logic [NPORTS-1:0]          out_ready,
  output logic [NPORTS-1:0]          in_ready,
  output logic [NPORTS-1:0]          out_valid,
  output logic [NPORTS*NPORTS-1:0]   out_sel,
`ifdef STAR_ALLOC_TIMEOUT_EN
  output logic [NPORTS-1:0]          alloc_timeout,
`endif
  output logic [NPORTS-1:0]          dest_err
);
  localparam int PW = $clog2(NPORTS);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} in_state_e;

  in_state_e         state_q  [NPORTS];
  in_state_e         state_d  [NPORTS];
  logic [PW-1:0]     target_q [NPORTS];
  logic [PW-1:0]     target_d [NPORTS];
  logic [NPORTS-1:0] sel_q    [NPORTS];  // per output: one-hot owning input
  logic [NPORTS-1:0] sel_d    [NPORTS];
  logic [PW-1:0]     ptr_q    [NPORTS];
  logic [PW-1:0]     ptr_d    [NPORTS];
  logic [NPORTS-1:0] dest_err_q;

  logic [DEST_W-1:0] hdr_dest [NPORTS];
  logic [NPORTS-1:0] dest_ok, drop, xfer_out, tail_rel, win_valid;
  logic [PW-1:0]     win_idx  [NPORTS];

`ifdef STAR_ALLOC_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0]     stall_q [NPORTS];
  logic [SW-1:0]     stall_d [NPORTS];
  logic [NPORTS-1:0] timeout_q, timeout_d;
  assign alloc_timeout = timeout_q;
`endif

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + 1 + k) % NPORTS);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these per-port arrays are plain flops, not a RAM, so they take reset like any other state.
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i]  <= IDLE;
        target_q[i] <= '0;
        sel_q[i]    <= '0;
        ptr_q[i]    <= PW'(NPORTS - 1);
`ifdef STAR_ALLOC_TIMEOUT_EN
        stall_q[i]  <= '0;
`endif
      end
      dest_err_q <= '0;
`ifdef STAR_ALLOC_TIMEOUT_EN
      timeout_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i]  <= state_d[i];
        target_q[i] <= target_d[i];
        sel_q[i]    <= sel_d[i];
        ptr_q[i]    <= ptr_d[i];
`ifdef STAR_ALLOC_TIMEOUT_EN
        stall_q[i]  <= stall_d[i];
`endif
      end
      dest_err_q <= drop;
`ifdef STAR_ALLOC_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Scan from the farthest candidate back to pointer+1 so the nearest one wins.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      win_valid[o] = 1'b0;
      win_idx[o]   = '0;
      for (int k = NPORTS - 1; k >= 0; k--) begin
        if (state_q[rr_idx(ptr_q[o], k)] == REQ && target_q[rr_idx(ptr_q[o], k)] == PW'(o)) begin
          win_valid[o] = 1'b1;
          win_idx[o]   = rr_idx(ptr_q[o], k);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    for (int i = 0; i < NPORTS; i++) begin
      state_d[i]  = state_q[i];
      target_d[i] = target_q[i];
      sel_d[i]    = sel_q[i];
      ptr_d[i]    = ptr_q[i];
`ifdef STAR_ALLOC_TIMEOUT_EN
      stall_d[i]   = stall_q[i];
      timeout_d[i] = 1'b0;
`endif
    end

    for (int i = 0; i < NPORTS; i++) begin
      if (state_q[i] == IDLE && in_valid[i] && dest_ok[i]) begin
        state_d[i]  = REQ;
        target_d[i] = PW'(hdr_dest[i] - DEST_W'(1));
      end
    end

    for (int o = 0; o < NPORTS; o++) begin
      if (sel_q[o] == '0) begin
        if (win_valid[o]) begin
          sel_d[o][win_idx[o]] = 1'b1;
          ptr_d[o]             = win_idx[o];
          state_d[win_idx[o]]  = ACTIVE;
        end
      end else if (tail_rel[o]) begin
        sel_d[o] = '0;
        for (int i = 0; i < NPORTS; i++)
          if (sel_q[o][i]) state_d[i] = IDLE;
      end
`ifdef STAR_ALLOC_TIMEOUT_EN
      if (sel_q[o] == '0 || xfer_out[o]) begin
        stall_d[o] = '0;
      end else if (stall_q[o] == SW'(TIMEOUT_CYC)) begin
        stall_d[o]   = '0;
        sel_d[o]     = '0;
        timeout_d[o] = 1'b1;
        for (int i = 0; i < NPORTS; i++)
          if (sel_q[o][i]) state_d[i] = IDLE;
      end else begin
        stall_d[o] = stall_q[o] + SW'(1);
      end
`endif
    end
  end

  // Flow control is purely combinational off the locks, so a granted path adds no latency.
  always_comb begin
    in_ready = '0;
    out_valid = '0;
    out_sel = '0;
    xfer_out = '0;
    tail_rel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      hdr_dest[i] = in_dest[i*DEST_W +: DEST_W];
      dest_ok[i]  = (hdr_dest[i] != '0) && (hdr_dest[i] <= DEST_W'(NPORTS));
      drop[i]     = !rst && state_q[i] == IDLE && in_valid[i] && !dest_ok[i];
      in_ready[i] = drop[i];
    end
    for (int o = 0; o < NPORTS; o++) begin
      out_sel[o*NPORTS +: NPORTS] = sel_q[o];
      out_valid[o] = |(sel_q[o] & in_valid);
      xfer_out[o]  = out_valid[o] & out_ready[o];
      tail_rel[o]  = xfer_out[o] & (|(sel_q[o] & in_tail));
      for (int i = 0; i < NPORTS; i++)
        if (sel_q[o][i]) in_ready[i] = out_ready[o];
    end
  end

  assign dest_err = dest_err_q;

endmodule
